// File: rtl/vscale_regfile_dbg.sv
// Debug-side initiator for the integer register file: halts the core, performs one
// register read or write through the regfile ports, then returns a response.
module vscale_regfile_dbg #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned AW           = 5,
    parameter int unsigned HALT_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            dbg_req_valid,
    output logic            dbg_req_ready,
    input  logic            dbg_req_wr,
    input  logic [AW-1:0]   dbg_req_addr,
    input  logic [XLEN-1:0] dbg_req_wdata,
    output logic            dbg_resp_valid,
    input  logic            dbg_resp_ready,
    output logic [XLEN-1:0] dbg_resp_rdata,
    output logic            dbg_resp_err,
    output logic            dbg_halt_req,
    input  logic            core_halted,
    output logic [AW-1:0]   rf_ra,
    input  logic [XLEN-1:0] rf_rd,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_wa,
    output logic [XLEN-1:0] rf_wd
);

    localparam int unsigned CW = $clog2(HALT_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_HALT, S_ACCESS, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]     count_q, count_d;
    logic              halt_q, halt_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              legal_wr;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            count_q      <= '0;
            halt_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            count_q      <= count_d;
            halt_q       <= halt_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        count_d      = count_q;
        halt_d       = halt_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (dbg_req_valid) begin
                    state_d = S_HALT;
                    wr_d    = dbg_req_wr;
                    addr_d  = dbg_req_addr;
                    wdata_d = dbg_req_wdata;
                    count_d = '0;
                    halt_d  = 1'b1;
                end
            end
            S_HALT: begin
                if (core_halted) begin
                    state_d = S_ACCESS;
                end else if (count_q == CW'(HALT_TIMEOUT - 1)) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    rdata_d      = '0;
                    err_d        = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            S_ACCESS: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                rdata_d      = (!wr_q && addr_q != '0) ? rf_rd : '0;
                err_d        = wr_q && (addr_q == '0);
            end
            S_RESP: begin
                if (dbg_resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    halt_d       = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // x0 writes are suppressed so the hardwired-zero register is never disturbed
    assign legal_wr       = (state_q == S_ACCESS) && wr_q && (addr_q != '0);
    assign dbg_req_ready  = (state_q == S_IDLE);
    assign rf_wen         = legal_wr;
    assign rf_wd          = legal_wr ? wdata_q : '0;
    assign rf_ra          = addr_q;
    assign rf_wa          = addr_q;
    assign dbg_halt_req   = halt_q;
    assign dbg_resp_valid = resp_valid_q;
    assign dbg_resp_rdata = rdata_q;
    assign dbg_resp_err   = err_q;

endmodule

// File: tb/tb_vscale_regfile_dbg.sv
// Bench for vscale_regfile_dbg: table of single-register requests against a small
// register-file and core-halt model, plus timeout, backpressure and reset sequences.
module tb_vscale_regfile_dbg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dbg_req_valid;
    logic        dbg_req_ready;
    logic        dbg_req_wr;
    logic [4:0]  dbg_req_addr;
    logic [31:0] dbg_req_wdata;
    logic        dbg_resp_valid;
    logic        dbg_resp_ready;
    logic [31:0] dbg_resp_rdata;
    logic        dbg_resp_err;
    logic        dbg_halt_req;
    logic        core_halted;
    logic [4:0]  rf_ra;
    logic [31:0] rf_rd;
    logic        rf_wen;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    logic        halt_en;
    logic [31:0] model [32];
    int          wen_cnt;
    logic [4:0]  last_wa;
    logic [31:0] last_wd;
    int          checks;
    int          failures;

    vscale_regfile_dbg dut (
        .clk(clk), .reset_n(reset_n),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_wr(dbg_req_wr), .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
        .dbg_resp_valid(dbg_resp_valid), .dbg_resp_ready(dbg_resp_ready),
        .dbg_resp_rdata(dbg_resp_rdata), .dbg_resp_err(dbg_resp_err),
        .dbg_halt_req(dbg_halt_req), .core_halted(core_halted),
        .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    // Core halts one cycle after being asked, unless the bench disables it
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) core_halted <= 1'b0;
        else          core_halted <= halt_en & dbg_halt_req;
    end

    // x0 reads return garbage so the DUT's zero gating is observable
    assign rf_rd = (rf_ra == 5'd0) ? 32'hBAD0_0BAD : model[rf_ra];

    always @(posedge clk) begin
        if (rf_wen) begin
            wen_cnt <= wen_cnt + 1;
            last_wa <= rf_wa;
            last_wd <= rf_wd;
            model[rf_wa] <= rf_wd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a request and return once it has been accepted
    task automatic send(input logic wr, input logic [4:0] addr, input logic [31:0] wdata);
        int n;
        @(negedge clk);
        dbg_req_valid = 1'b1;
        dbg_req_wr    = wr;
        dbg_req_addr  = addr;
        dbg_req_wdata = wdata;
        n = 0;
        while (!dbg_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        dbg_req_valid = 1'b0;
    endtask

    // Count cycles from acceptance until a response appears
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!dbg_resp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!dbg_resp_valid) chk("resp_timeout", 32'(lat), 32'd0);
    endtask

    task automatic handshake();
        @(negedge clk);
        dbg_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        dbg_resp_ready = 1'b0;
        chk("resp_valid_drop", 32'(dbg_resp_valid), 32'd0);
        chk("halt_req_drop", 32'(dbg_halt_req), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_wen;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat;
        int w0;
        logic [31:0] r0;
        logic        e0;

        checks = 0; failures = 0; wen_cnt = 0; last_wa = '0; last_wd = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        halt_en = 1'b1;
        reset_n = 1'b0;
        dbg_req_valid = 1'b0; dbg_req_wr = 1'b0; dbg_req_addr = '0; dbg_req_wdata = '0;
        dbg_resp_ready = 1'b0;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 32'h0,        1'b0, 1, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 0, 32'h0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 0, 32'h0};
        vecs[3] = '{1'b1, 5'd0,  32'h00001234, 32'h0,        1'b1, 0, 32'h0};
        vecs[4] = '{1'b1, 5'd31, 32'h00000001, 32'h0,        1'b0, 1, 32'h00000001};
        vecs[5] = '{1'b0, 5'd31, 32'h0,        32'h00000001, 1'b0, 0, 32'h0};
        vecs[6] = '{1'b1, 5'd7,  32'hA5A5A5A5, 32'h0,        1'b0, 1, 32'hA5A5A5A5};
        vecs[7] = '{1'b0, 5'd7,  32'h0,        32'hA5A5A5A5, 1'b0, 0, 32'h0};
        vecs[8] = '{1'b0, 5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 0, 32'h0};

        #12;
        chk("rst_req_ready", 32'(dbg_req_ready), 32'd1);
        chk("rst_resp_valid", 32'(dbg_resp_valid), 32'd0);
        chk("rst_halt_req", 32'(dbg_halt_req), 32'd0);
        chk("rst_rf_wen", 32'(rf_wen), 32'd0);
        chk("rst_rf_ra", 32'(rf_ra), 32'd0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_rdata", dbg_resp_rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table of single requests
        foreach (vecs[i]) begin
            w0 = wen_cnt;
            send(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("v%0d_halt_req", i), 32'(dbg_halt_req), 32'd1);
            chk($sformatf("v%0d_req_ready", i), 32'(dbg_req_ready), 32'd0);
            wait_resp(lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("v%0d_rdata", i), dbg_resp_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(dbg_resp_err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_wen_pulses", i), 32'(wen_cnt - w0), 32'(vecs[i].exp_wen));
            if (vecs[i].exp_wen != 0) begin
                chk($sformatf("v%0d_wa", i), 32'(last_wa), 32'(vecs[i].addr));
                chk($sformatf("v%0d_wd", i), last_wd, vecs[i].exp_wd);
            end
            handshake();
        end

        // Halt timeout: core never stalls
        halt_en = 1'b0;
        w0 = wen_cnt;
        send(1'b1, 5'd3, 32'h00000055);
        wait_resp(lat);
        chk("to_latency", 32'(lat), 32'd64);
        chk("to_err", 32'(dbg_resp_err), 32'd1);
        chk("to_rdata", dbg_resp_rdata, 32'd0);
        chk("to_halt_held", 32'(dbg_halt_req), 32'd1);
        chk("to_no_wen", 32'(wen_cnt - w0), 32'd0);
        handshake();
        halt_en = 1'b1;

        // Response backpressure with a second request waiting
        send(1'b0, 5'd5, 32'h0);
        wait_resp(lat);
        r0 = dbg_resp_rdata;
        e0 = dbg_resp_err;
        chk("bp_rdata", r0, 32'hDEADBEEF);
        @(negedge clk);
        dbg_req_valid = 1'b1; dbg_req_wr = 1'b0; dbg_req_addr = 5'd7; dbg_req_wdata = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("bp_stable_rdata_%0d", c), dbg_resp_rdata, 32'hDEADBEEF);
            chk($sformatf("bp_stable_err_%0d", c), 32'(dbg_resp_err), 32'(e0));
            chk($sformatf("bp_valid_%0d", c), 32'(dbg_resp_valid), 32'd1);
            chk($sformatf("bp_no_accept_%0d", c), 32'(dbg_req_ready), 32'd0);
        end
        dbg_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        dbg_resp_ready = 1'b0;
        chk("bp_gap_halt_low", 32'(dbg_halt_req), 32'd0);
        chk("bp_gap_ready", 32'(dbg_req_ready), 32'd1);
        @(posedge clk);
        #1;
        dbg_req_valid = 1'b0;
        chk("bp_second_accepted", 32'(dbg_halt_req), 32'd1);
        wait_resp(lat);
        chk("bp_second_latency", 32'(lat), 32'd3);
        chk("bp_second_rdata", dbg_resp_rdata, 32'hA5A5A5A5);
        handshake();

        // Asynchronous reset while a response is pending
        send(1'b0, 5'd31, 32'h0);
        wait_resp(lat);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", 32'(dbg_resp_valid), 32'd0);
        chk("mid_rst_halt_req", 32'(dbg_halt_req), 32'd0);
        chk("mid_rst_rf_wen", 32'(rf_wen), 32'd0);
        chk("mid_rst_req_ready", 32'(dbg_req_ready), 32'd1);
        chk("mid_rst_rdata", dbg_resp_rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset during HALT drops an in-flight write
        w0 = wen_cnt;
        send(1'b1, 5'd9, 32'h99999999);
        #2;
        reset_n = 1'b0;
        #1;
        chk("drop_halt_req", 32'(dbg_halt_req), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drop_no_wen", 32'(wen_cnt - w0), 32'd0);
        chk("drop_no_resp", 32'(dbg_resp_valid), 32'd0);
        chk("drop_model_x9", model[9], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
